// File: rtl/matvec_mult_param.sv
// matvec_mult_param: parametrised matrix-vector multiplier, y = A * x.
//
// Each matrix row is loaded into its own COLS-deep FIFO and the vector into a
// further FIFO. A start with every FIFO full launches the computation. The
// vector streams through a skewed shift chain so that MAC row r sees x[t-r]
// while popping its own row FIFO. Results may be accumulated across tiles
// (acc_keep).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   clr             synchronous flush of FIFOs/accumulators, return to IDLE
//   start, acc_keep start pulse; acc_keep=1 keeps previous sums
//   wr_en, wr_sel,  element write; wr_sel 0..ROWS-1 = matrix row,
//   wr_data         ROWS = vector
//   wr_ready        writes accepted (IDLE or DONE)
//   wr_err          pulse: write dropped
//   start_err       pulse: start rejected (some FIFO not full)
//   busy, done      COMPUTE / DONE state flags
//   result          row r sum at [r*ACC_W +: ACC_W]
module matvec_mult_param #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DW     = 8,
  parameter int ACC_W  = 24,
  parameter bit SIGNED = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      start,
  input  logic                      acc_keep,
  input  logic                      wr_en,
  input  logic [$clog2(ROWS+1)-1:0] wr_sel,
  input  logic [DW-1:0]             wr_data,
  output logic                      wr_ready,
  output logic                      wr_err,
  output logic                      start_err,
  output logic                      busy,
  output logic                      done,
  output logic [ROWS*ACC_W-1:0]     result
);

  localparam int NF = ROWS + 1;
  localparam int CW = $clog2(COLS + 1);
  localparam int IW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TW = $clog2(ROWS + COLS + 1);
  localparam logic [CW-1:0] COLS_C = CW'(COLS);
  // One cycle beyond the last pop step drains the MAC operand register.
  localparam logic [TW-1:0] T_LAST = TW'(ROWS + COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t                  state;
  logic [TW-1:0]           t;
  logic [CW-1:0]           cnt      [NF];
  logic [DW-1:0]           mem      [NF][COLS];
  logic signed [ACC_W-1:0] acc      [ROWS];
  logic [DW-1:0]           row_head [ROWS];
  logic [DW-1:0]           x_stage  [ROWS];
  logic [DW-1:0]           a_p0     [ROWS];
  logic [DW-1:0]           x_p0     [ROWS];
  logic [ROWS-1:0]         en_p0;
  logic [ROWS-1:0]         pop_row;
  logic                    pop_vec;
  logic                    all_full;
  logic                    wr_ok;
  logic                    wr_accept;

  // FIFOs always drain completely, so the read slot is COLS minus occupancy.
  function automatic logic [IW-1:0] rd_idx(input logic [CW-1:0] c);
    logic [CW-1:0] d;
    d = COLS_C - c;
    return d[IW-1:0];
  endfunction

  // Full-width product, extended to the accumulator width per SIGNED.
  function automatic logic signed [ACC_W-1:0] mac_term(input logic [DW-1:0] a,
                                                       input logic [DW-1:0] x);
    logic signed [2*DW-1:0] as, xs, ps;
    logic [2*DW-1:0]        pu;
    if (SIGNED) begin
      as = (2*DW)'($signed(a));
      xs = (2*DW)'($signed(x));
      ps = as * xs;
      return ACC_W'(ps);
    end else begin
      pu = (2*DW)'(a) * (2*DW)'(x);
      return ACC_W'(pu);
    end
  endfunction

  always_comb begin
    all_full = 1'b1;
    wr_ok    = 1'b0;
    for (int f = 0; f < NF; f++) begin
      if (cnt[f] != COLS_C) all_full = 1'b0;
      if (int'(wr_sel) == f && cnt[f] != COLS_C) wr_ok = 1'b1;
    end
    wr_accept = wr_en && !clr && (state != S_COMPUTE) && wr_ok;
    pop_vec   = (state == S_COMPUTE) && (int'(t) < COLS);
    pop_row   = '0;
    for (int r = 0; r < ROWS; r++) begin
      pop_row[r]  = (state == S_COMPUTE) && (int'(t) >= r) && (int'(t) < r + COLS);
      row_head[r] = mem[r][rd_idx(cnt[r])];
    end
  end

  assign x_stage[0] = pop_vec ? mem[ROWS][rd_idx(cnt[ROWS])] : '0;

  // Skew chain: stage r carries stage r-1 delayed one cycle.
  if (ROWS > 1) begin : g_skew
    logic [DW-1:0] skew_q [ROWS-1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < ROWS-1; i++) skew_q[i] <= '0;
      end else if (clr) begin
        for (int i = 0; i < ROWS-1; i++) skew_q[i] <= '0;
      end else begin
        skew_q[0] <= x_stage[0];
        for (int i = 1; i < ROWS-1; i++) skew_q[i] <= skew_q[i-1];
      end
    end
    for (genvar r = 1; r < ROWS; r++) begin : g_tap
      assign x_stage[r] = skew_q[r-1];
    end
  end

  // FIFO storage: written at the occupancy slot.
  always_ff @(posedge clk) begin
    for (int f = 0; f < NF; f++)
      if (wr_accept && int'(wr_sel) == f) mem[f][cnt[f][IW-1:0]] <= wr_data;
  end

  // ---- stage p0: MAC operands captured from FIFO heads and skew taps ----
  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      a_p0[r] <= row_head[r];
      x_p0[r] <= x_stage[r];
    end
  end

  // ---- stage p1: accumulate, FIFO occupancy, control FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      t         <= '0;
      wr_err    <= 1'b0;
      start_err <= 1'b0;
      en_p0     <= '0;
      for (int f = 0; f < NF; f++) cnt[f] <= '0;
      for (int r = 0; r < ROWS; r++) acc[r] <= '0;
    end else begin
      wr_err    <= 1'b0;
      start_err <= 1'b0;
      if (clr) begin
        state <= S_IDLE;
        t     <= '0;
        en_p0 <= '0;
        for (int f = 0; f < NF; f++) cnt[f] <= '0;
        for (int r = 0; r < ROWS; r++) acc[r] <= '0;
      end else begin
        en_p0 <= pop_row;
        for (int r = 0; r < ROWS; r++)
          if (en_p0[r]) acc[r] <= acc[r] + mac_term(a_p0[r], x_p0[r]);
        case (state)
          S_IDLE, S_DONE: begin
            if (start && all_full) begin
              state <= S_COMPUTE;
              t     <= '0;
              if (!acc_keep)
                for (int r = 0; r < ROWS; r++) acc[r] <= '0;
            end else if (start) begin
              start_err <= 1'b1;
            end
            if (wr_en && !wr_ok) wr_err <= 1'b1;
            for (int f = 0; f < NF; f++)
              if (wr_accept && int'(wr_sel) == f) cnt[f] <= cnt[f] + 1'b1;
          end
          S_COMPUTE: begin
            if (wr_en) wr_err <= 1'b1;
            if (t == T_LAST) state <= S_DONE;
            else             t     <= t + 1'b1;
            for (int r = 0; r < ROWS; r++)
              if (pop_row[r]) cnt[r] <= cnt[r] - 1'b1;
            if (pop_vec) cnt[ROWS] <= cnt[ROWS] - 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign wr_ready = (state != S_COMPUTE);
  assign busy     = (state == S_COMPUTE);
  assign done     = (state == S_DONE);

  always_comb begin
    result = '0;
    for (int r = 0; r < ROWS; r++) result[r*ACC_W +: ACC_W] = acc[r];
  end

endmodule

// File: tb/tb_matvec_mult_param.sv
module tb_matvec_mult_param;
  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int DW    = 8;
  localparam int ACC_W = 24;
  localparam int SW    = $clog2(ROWS + 1);

  logic clk = 1'b0;
  logic rst, clr, start, acc_keep, wr_en;
  logic [SW-1:0] wr_sel;
  logic [DW-1:0] wr_data;
  logic u_wr_ready, u_wr_err, u_start_err, u_busy, u_done;
  logic s_wr_ready, s_wr_err, s_start_err, s_busy, s_done;
  logic [ROWS*ACC_W-1:0] u_result, s_result;

  // Two copies share all stimulus: unsigned and signed operand modes.
  matvec_mult_param #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACC_W(ACC_W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .acc_keep(acc_keep),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_ready(u_wr_ready), .wr_err(u_wr_err), .start_err(u_start_err),
    .busy(u_busy), .done(u_done), .result(u_result));

  matvec_mult_param #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACC_W(ACC_W), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .acc_keep(acc_keep),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_ready(s_wr_ready), .wr_err(s_wr_err), .start_err(s_start_err),
    .busy(s_busy), .done(s_done), .result(s_result));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  int A [ROWS][COLS];
  int X [COLS];
  logic [ACC_W-1:0] m_u [ROWS];
  logic [ACC_W-1:0] m_s [ROWS];

  // ---------------- reference model ----------------
  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) begin
      m_u[r] = '0;
      m_s[r] = '0;
    end
  endtask

  task automatic model_run(input bit keep);
    longint su, ss;
    for (int r = 0; r < ROWS; r++) begin
      su = 0;
      ss = 0;
      for (int c = 0; c < COLS; c++) begin
        su += longint'(A[r][c] * X[c]);
        ss += longint'(sx(A[r][c]) * sx(X[c]));
      end
      if (!keep) begin
        m_u[r] = '0;
        m_s[r] = '0;
      end
      m_u[r] = m_u[r] + ACC_W'(su);
      m_s[r] = m_s[r] + ACC_W'(ss);
    end
  endtask

  task automatic set_const(input int a, input int x);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) A[r][c] = a;
    for (int c = 0; c < COLS; c++) X[c] = x;
  endtask

  task automatic set_identity();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) A[r][c] = (r == c) ? 1 : 0;
    for (int c = 0; c < COLS; c++) X[c] = c + 1;
  endtask

  task automatic set_random();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) A[r][c] = int'($urandom_range(0, 255));
    for (int c = 0; c < COLS; c++) X[c] = int'($urandom_range(0, 255));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int sel, input int d);
    wr_en   = 1'b1;
    wr_sel  = SW'(sel);
    wr_data = DW'(d);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic load_tile(input bit inter);
    if (inter) begin
      for (int c = 0; c < COLS; c++) begin
        for (int r = 0; r < ROWS; r++) wr(r, A[r][c]);
        wr(ROWS, X[c]);
      end
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) wr(r, A[r][c]);
      for (int c = 0; c < COLS; c++) wr(ROWS, X[c]);
    end
  endtask

  // Start edge counts as 0; lat = edges until done, -1 if never.
  task automatic run_tile(input bit keep, output int lat);
    start    = 1'b1;
    acc_keep = keep;
    step();
    start    = 1'b0;
    acc_keep = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (u_done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (u_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready_u got %b want 1", u_wr_ready); end
    n_cmp++; if (s_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready_s got %b want 1", s_wr_ready); end
    n_cmp++; if (u_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_u got %b want 0", u_busy); end
    n_cmp++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_s got %b want 0", s_busy); end
    n_cmp++; if (u_done !== 1'b0) begin n_fail++; $display("FAIL reset_done_u got %b want 0", u_done); end
    n_cmp++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL reset_done_s got %b want 0", s_done); end
    n_cmp++; if (u_wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err got %b want 0", u_wr_err); end
    n_cmp++; if (u_start_err !== 1'b0) begin n_fail++; $display("FAIL reset_start_err got %b want 0", u_start_err); end
    n_cmp++; if (u_result !== '0) begin n_fail++; $display("FAIL reset_result_u got %h want 0", u_result); end
    n_cmp++; if (s_result !== '0) begin n_fail++; $display("FAIL reset_result_s got %h want 0", s_result); end
    model_clear();
  endtask

  task automatic test_identity();
    int lat;
    set_identity();
    load_tile(1'b0);
    model_run(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (u_busy !== 1'b1) begin n_fail++; $display("FAIL ident_busy got %b want 1", u_busy); end
    n_cmp++; if (u_wr_ready !== 1'b0) begin n_fail++; $display("FAIL ident_wr_ready got %b want 0", u_wr_ready); end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (u_done === 1'b1) begin
        lat = n;
        break;
      end
    end
    n_cmp++; if (lat != 16) begin n_fail++; $display("FAIL ident_latency got %0d want 16", lat); end
    n_cmp++; if (s_done !== 1'b1) begin n_fail++; $display("FAIL ident_done_s got %b want 1", s_done); end
    for (int r = 0; r < ROWS; r++) begin
      n_cmp++;
      if (u_result[r*ACC_W +: ACC_W] !== ACC_W'(r + 1)) begin
        n_fail++; $display("FAIL ident_u row%0d got %0d want %0d", r, u_result[r*ACC_W +: ACC_W], r + 1);
      end
      n_cmp++;
      if (s_result[r*ACC_W +: ACC_W] !== m_s[r]) begin
        n_fail++; $display("FAIL ident_s row%0d got %0d want %0d", r, s_result[r*ACC_W +: ACC_W], m_s[r]);
      end
    end
    // DONE must hold its result.
    step(); step(); step();
    n_cmp++; if (u_done !== 1'b1) begin n_fail++; $display("FAIL ident_hold_done got %b want 1", u_done); end
    for (int r = 0; r < ROWS; r++) begin
      n_cmp++;
      if (u_result[r*ACC_W +: ACC_W] !== m_u[r]) begin
        n_fail++; $display("FAIL ident_hold row%0d got %0d want %0d", r, u_result[r*ACC_W +: ACC_W], m_u[r]);
      end
    end
  endtask

  task automatic test_full_scale();
    int lat;
    set_const(255, 255);
    load_tile(1'b1);
    model_run(1'b0);
    run_tile(1'b0, lat);
    n_cmp++; if (lat != 16) begin n_fail++; $display("FAIL full_latency got %0d want 16", lat); end
    for (int r = 0; r < ROWS; r++) begin
      n_cmp++;
      if (u_result[r*ACC_W +: ACC_W] !== 24'h07F008) begin
        n_fail++; $display("FAIL full_u row%0d got %h want 07f008", r, u_result[r*ACC_W +: ACC_W]);
      end
      n_cmp++;
      if (s_result[r*ACC_W +: ACC_W] !== m_s[r]) begin
        n_fail++; $display("FAIL full_s row%0d got %h want %h", r, s_result[r*ACC_W +: ACC_W], m_s[r]);
      end
    end
  endtask

  task automatic test_signed();
    int lat;
    set_const(8'h80, 8'h7F);
    load_tile(1'b0);
    model_run(1'b0);
    run_tile(1'b0, lat);
    n_cmp++; if (lat != 16) begin n_fail++; $display("FAIL signed_latency got %0d want 16", lat); end
    for (int r = 0; r < ROWS; r++) begin
      n_cmp++;
      if (s_result[r*ACC_W +: ACC_W] !== 24'hFE0400) begin
        n_fail++; $display("FAIL signed_s row%0d got %h want fe0400", r, s_result[r*ACC_W +: ACC_W]);
      end
      n_cmp++;
      if (u_result[r*ACC_W +: ACC_W] !== m_u[r]) begin
        n_fail++; $display("FAIL signed_u row%0d got %h want %h", r, u_result[r*ACC_W +: ACC_W], m_u[r]);
      end
    end
  endtask

  task automatic test_accumulate();
    int lat;
    set_const(1, 1);
    load_tile(1'b0);
    run_tile(1'b0, lat);
    for (int r = 0; r < ROWS; r++) begin
      n_cmp++;
      if (u_result[r*ACC_W +: ACC_W] !== 24'd8) begin
        n_fail++; $display("FAIL acc_tile1 row%0d got %0d want 8", r, u_result[r*ACC_W +: ACC_W]);
      end
    end
    load_tile(1'b1);
    run_tile(1'b1, lat);
    n_cmp++; if (lat != 16) begin n_fail++; $display("FAIL acc_latency got %0d want 16", lat); end
    for (int r = 0; r < ROWS; r++) begin
      n_cmp++;
      if (u_result[r*ACC_W +: ACC_W] !== 24'd16) begin
        n_fail++; $display("FAIL acc_tile2_u row%0d got %0d want 16", r, u_result[r*ACC_W +: ACC_W]);
      end
      n_cmp++;
      if (s_result[r*ACC_W +: ACC_W] !== 24'd16) begin
        n_fail++; $display("FAIL acc_tile2_s row%0d got %0d want 16", r, s_result[r*ACC_W +: ACC_W]);
      end
    end
    set_const(1, 1);
    model_clear();
    model_run(1'b1);
    model_run(1'b1);
  endtask

  task automatic test_random();
    int lat;
    bit keep;
    for (int it = 0; it < 4; it++) begin
      set_random();
      keep = bit'($urandom_range(0, 1));
      load_tile(bit'($urandom_range(0, 1)));
      model_run(keep);
      run_tile(keep, lat);
      n_cmp++; if (lat != 16) begin n_fail++; $display("FAIL rand%0d_latency got %0d want 16", it, lat); end
      for (int r = 0; r < ROWS; r++) begin
        n_cmp++;
        if (u_result[r*ACC_W +: ACC_W] !== m_u[r]) begin
          n_fail++; $display("FAIL rand%0d_u row%0d got %h want %h", it, r, u_result[r*ACC_W +: ACC_W], m_u[r]);
        end
        n_cmp++;
        if (s_result[r*ACC_W +: ACC_W] !== m_s[r]) begin
          n_fail++; $display("FAIL rand%0d_s row%0d got %h want %h", it, r, s_result[r*ACC_W +: ACC_W], m_s[r]);
        end
      end
    end
  endtask

  task automatic test_errors();
    int lat;
    set_random();
    model_run(1'b0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wr(r, A[r][c]);
    for (int c = 0; c < COLS-1; c++) wr(ROWS, X[c]);
    // Ninth write to a full row FIFO.
    wr(3, 8'hAA);
    n_cmp++; if (u_wr_err !== 1'b1) begin n_fail++; $display("FAIL err_row_full got %b want 1", u_wr_err); end
    step();
    n_cmp++; if (u_wr_err !== 1'b0) begin n_fail++; $display("FAIL err_wr_pulse got %b want 0", u_wr_err); end
    // Start with vector FIFO holding 7 entries.
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (u_start_err !== 1'b1) begin n_fail++; $display("FAIL err_start got %b want 1", u_start_err); end
    n_cmp++; if (u_busy !== 1'b0) begin n_fail++; $display("FAIL err_start_busy got %b want 0", u_busy); end
    step();
    n_cmp++; if (u_start_err !== 1'b0) begin n_fail++; $display("FAIL err_start_pulse got %b want 0", u_start_err); end
    // Out-of-range select.
    wr(ROWS + 1, 8'h33);
    n_cmp++; if (u_wr_err !== 1'b1) begin n_fail++; $display("FAIL err_bad_sel got %b want 1", u_wr_err); end
    wr(ROWS, X[COLS-1]);
    n_cmp++; if (u_wr_err !== 1'b0) begin n_fail++; $display("FAIL err_good_wr got %b want 0", u_wr_err); end
    start = 1'b1;
    step();
    start = 1'b0;
    // Write during COMPUTE.
    wr(2, 8'h55);
    n_cmp++; if (u_wr_err !== 1'b1) begin n_fail++; $display("FAIL err_wr_compute got %b want 1", u_wr_err); end
    lat = -1;
    for (int n = 2; n <= 40; n++) begin
      step();
      if (u_done === 1'b1) begin
        lat = n;
        break;
      end
    end
    n_cmp++; if (lat != 16) begin n_fail++; $display("FAIL err_latency got %0d want 16", lat); end
    for (int r = 0; r < ROWS; r++) begin
      n_cmp++;
      if (u_result[r*ACC_W +: ACC_W] !== m_u[r]) begin
        n_fail++; $display("FAIL err_u row%0d got %h want %h", r, u_result[r*ACC_W +: ACC_W], m_u[r]);
      end
      n_cmp++;
      if (s_result[r*ACC_W +: ACC_W] !== m_s[r]) begin
        n_fail++; $display("FAIL err_s row%0d got %h want %h", r, s_result[r*ACC_W +: ACC_W], m_s[r]);
      end
    end
  endtask

  task automatic test_clear();
    int lat;
    set_random();
    load_tile(1'b0);
    start    = 1'b1;
    acc_keep = 1'b1;
    step();
    start    = 1'b0;
    acc_keep = 1'b0;
    for (int n = 0; n < 5; n++) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_clear();
    n_cmp++; if (u_busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy got %b want 0", u_busy); end
    n_cmp++; if (u_done !== 1'b0) begin n_fail++; $display("FAIL clr_done got %b want 0", u_done); end
    n_cmp++; if (u_wr_ready !== 1'b1) begin n_fail++; $display("FAIL clr_wr_ready got %b want 1", u_wr_ready); end
    n_cmp++; if (u_result !== '0) begin n_fail++; $display("FAIL clr_result_u got %h want 0", u_result); end
    n_cmp++; if (s_result !== '0) begin n_fail++; $display("FAIL clr_result_s got %h want 0", s_result); end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (u_start_err !== 1'b1) begin n_fail++; $display("FAIL clr_empty_start got %b want 1", u_start_err); end
    // A fresh tile after the flush must compute cleanly from zero.
    set_random();
    load_tile(1'b1);
    model_run(1'b1);
    run_tile(1'b1, lat);
    n_cmp++; if (lat != 16) begin n_fail++; $display("FAIL clr_latency got %0d want 16", lat); end
    for (int r = 0; r < ROWS; r++) begin
      n_cmp++;
      if (u_result[r*ACC_W +: ACC_W] !== m_u[r]) begin
        n_fail++; $display("FAIL clr_after_u row%0d got %h want %h", r, u_result[r*ACC_W +: ACC_W], m_u[r]);
      end
      n_cmp++;
      if (s_result[r*ACC_W +: ACC_W] !== m_s[r]) begin
        n_fail++; $display("FAIL clr_after_s row%0d got %h want %h", r, s_result[r*ACC_W +: ACC_W], m_s[r]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    set_random();
    load_tile(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 5; n++) step();
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (u_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", u_busy); end
    n_cmp++; if (u_wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_wr_ready got %b want 1", u_wr_ready); end
    n_cmp++; if (u_result !== '0) begin n_fail++; $display("FAIL rst_mid_result got %h want 0", u_result); end
    step();
    rst = 1'b0;
    step();
    model_clear();
    set_identity();
    load_tile(1'b0);
    model_run(1'b1);
    run_tile(1'b1, lat);
    n_cmp++; if (lat != 16) begin n_fail++; $display("FAIL rst_ident_latency got %0d want 16", lat); end
    for (int r = 0; r < ROWS; r++) begin
      n_cmp++;
      if (u_result[r*ACC_W +: ACC_W] !== ACC_W'(r + 1)) begin
        n_fail++; $display("FAIL rst_ident row%0d got %0d want %0d", r, u_result[r*ACC_W +: ACC_W], r + 1);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    clr      = 1'b0;
    start    = 1'b0;
    acc_keep = 1'b0;
    wr_en    = 1'b0;
    wr_sel   = '0;
    wr_data  = '0;
    test_reset();
    test_identity();
    test_full_scale();
    test_signed();
    test_accumulate();
    test_random();
    test_errors();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
